locker_seq_ctrl: RTL



---
 rtl/locker_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/locker_seq_ctrl.sv
// Sequencing controller for the Locker combination lock: code entry, RS-latch pulsing, lockout.
// Optional auto-relock from OPEN is enabled by defining LOCKER_AUTO_RELOCK_EN.
module locker_seq_ctrl #(
   parameter logic [15:0] CODE            = 16'h2418,
   parameter int          MAX_ERR         = 3,
   parameter int          LOCKOUT_CYC     = 1000,
   parameter int          PULSE_CYC       = 2,
   parameter int          AUTO_RELOCK_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_val,
   input  logic       lock_cmd,
   output logic       latch_c,
   output logic       latch_s,
   output logic       latch_r,
   output logic [2:0] digit_cnt,
   output logic [2:0] err_cnt,
   output logic       lockout,
   output logic       is_open
);

   localparam int TMAX_A = (LOCKOUT_CYC > AUTO_RELOCK_CYC) ? LOCKOUT_CYC : AUTO_RELOCK_CYC;
   localparam int TMAX   = (TMAX_A > PULSE_CYC) ? TMAX_A : PULSE_CYC;
   localparam int TW     = $clog2(TMAX + 1);

   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYC);
   localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_CYC);
`ifdef LOCKER_AUTO_RELOCK_EN
   localparam logic [TW-1:0] T_AUTO  = TW'(AUTO_RELOCK_CYC);
`endif
   localparam logic [3:0]    KEY_CLR = 4'hF;
   localparam logic [2:0]    ERR_LAST = 3'(MAX_ERR - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_RST_PULSE,
      S_IDLE,
      S_CHECK,
      S_SET_PULSE,
      S_OPEN,
      S_LOCKOUT
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic            mismatch;
   logic [4:0]      outs;

   // Output vector {latch_c, latch_s, latch_r, lockout, is_open} for a given state.
   function automatic logic [4:0] decode(input state_t s);
      case (s)
         S_RST_PULSE: decode = 5'b10100;
         S_SET_PULSE: decode = 5'b11000;
         S_OPEN:      decode = 5'b00001;
         S_LOCKOUT:   decode = 5'b00010;
         default:     decode = 5'b00000;
      endcase
   endfunction

   function automatic logic [3:0] code_digit(input logic [1:0] idx);
      case (idx)
         2'd0:    code_digit = CODE[15:12];
         2'd1:    code_digit = CODE[11:8];
         2'd2:    code_digit = CODE[7:4];
         default: code_digit = CODE[3:0];
      endcase
   endfunction

   assign {latch_c, latch_s, latch_r, lockout, is_open} = outs;

   // Outputs are loaded together with each state change so they come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_INIT;
         timer     <= '0;
         digit_cnt <= '0;
         err_cnt   <= '0;
         mismatch  <= 1'b0;
         outs      <= '0;
      end else begin
         case (state)
            S_INIT: begin
               state <= S_RST_PULSE;
               outs  <= decode(S_RST_PULSE);
               timer <= T_PULSE;
            end

            S_RST_PULSE, S_SET_PULSE: begin
               if (timer == T_ONE) begin
                  if (state == S_SET_PULSE) begin
                     state <= S_OPEN;
                     outs  <= decode(S_OPEN);
`ifdef LOCKER_AUTO_RELOCK_EN
                     timer <= T_AUTO;
`endif
                  end else begin
                     state     <= S_IDLE;
                     outs      <= decode(S_IDLE);
                     digit_cnt <= '0;
                  end
               end else begin
                  timer <= timer - T_ONE;
               end
            end

            S_IDLE: begin
               if (key_valid) begin
                  if (key_val == KEY_CLR) begin
                     digit_cnt <= '0;
                     mismatch  <= 1'b0;
                  end else begin
                     // Keys 10-14 count as a digit but can never match.
                     if ((key_val > 4'd9) || (key_val != code_digit(digit_cnt[1:0])))
                        mismatch <= 1'b1;
                     digit_cnt <= digit_cnt + 3'd1;
                     if (digit_cnt == 3'd3) begin
                        state <= S_CHECK;
                        outs  <= decode(S_CHECK);
                     end
                  end
               end
            end

            S_CHECK: begin
               digit_cnt <= '0;
               mismatch  <= 1'b0;
               if (!mismatch) begin
                  err_cnt <= '0;
                  state   <= S_SET_PULSE;
                  outs    <= decode(S_SET_PULSE);
                  timer   <= T_PULSE;
               end else if (err_cnt == ERR_LAST) begin
                  err_cnt <= err_cnt + 3'd1;
                  state   <= S_LOCKOUT;
                  outs    <= decode(S_LOCKOUT);
                  timer   <= T_LOCK;
               end else begin
                  err_cnt <= err_cnt + 3'd1;
                  state   <= S_IDLE;
                  outs    <= decode(S_IDLE);
               end
            end

            S_OPEN: begin
               if (lock_cmd) begin
                  state <= S_RST_PULSE;
                  outs  <= decode(S_RST_PULSE);
                  timer <= T_PULSE;
               end
`ifdef LOCKER_AUTO_RELOCK_EN
               else if (timer == T_ONE) begin
                  state <= S_RST_PULSE;
                  outs  <= decode(S_RST_PULSE);
                  timer <= T_PULSE;
               end else begin
                  timer <= timer - T_ONE;
               end
`endif
            end

            S_LOCKOUT: begin
               if (timer == T_ONE) begin
                  err_cnt <= '0;
                  state   <= S_IDLE;
                  outs    <= decode(S_IDLE);
               end else begin
                  timer <= timer - T_ONE;
               end
            end

            default: begin
               state <= S_INIT;
               outs  <= '0;
            end
         endcase
      end
   end

endmodule
